neighbor_info_banked_engine: RTL and testbench

NEIGHBOR_INFO_BANKED_ENGINE -- requirements
Module: neighbor_info_banked_engine

---
 rtl/neighbor_info_banked_engine_pkg.sv | 38 +++
 rtl/neighbor_info_banked_engine_if.sv | 39 +++
 rtl/neighbor_info_banked_engine_req_fifo.sv | 60 ++++++
 rtl/neighbor_info_banked_engine.sv | 140 ++++++++++++++
 tb/tb_neighbor_info_banked_engine.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/neighbor_info_banked_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : neighbor_info_banked_engine_pkg
//  Purpose  : Shared types and default constants for the banked neighbor-info
//             engine: request entry struct, FSM state enum, op encoding.
//  Ports    : (package - none)
//  Revision : 1.0 - initial release
// ============================================================================
package neighbor_info_banked_engine_pkg;

  // Default configuration
  localparam int NI_NUM_BANK   = 4;
  localparam int NI_DATA_W     = 16;
  localparam int NI_DEPTH      = 128;
  localparam int NI_FIFO_DEPTH = 8;

  // Request fields are sized for the widest supported configuration
  // (address up to 32 bits, data up to 64 bits); the engine zero-extends on
  // push and only ever reads back its own low-order bits.
  localparam int NI_ADDR_MAX_W = 32;
  localparam int NI_DATA_MAX_W = 64;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef struct packed {
    logic                     op;
    logic [NI_ADDR_MAX_W-1:0] addr;
    logic [NI_DATA_MAX_W-1:0] wdata;
  } neighbor_info_req_t;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } neighbor_info_state_t;

endpackage
`default_nettype wire

// File: rtl/neighbor_info_banked_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : neighbor_info_banked_engine_if
//  Purpose  : Request / response bus of the banked neighbor-info engine.
//  Signals  : req_valid, req_op, req_addr, req_wdata, req_ready (request side)
//             out_full, out_valid, out_data, out_bank      (response side)
//  Modports : master - traffic source / downstream sink
//             slave  - the engine
//  Revision : 1.0 - initial release
// ============================================================================
interface neighbor_info_banked_engine_if #(
  parameter int NUM_BANK = neighbor_info_banked_engine_pkg::NI_NUM_BANK,
  parameter int DATA_W   = neighbor_info_banked_engine_pkg::NI_DATA_W,
  parameter int DEPTH    = neighbor_info_banked_engine_pkg::NI_DEPTH
) ();
  localparam int c_aw = $clog2(NUM_BANK * DEPTH);
  localparam int c_bw = $clog2(NUM_BANK);

  logic              req_valid;
  logic              req_op;
  logic [c_aw-1:0]   req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              out_full;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [c_bw-1:0]   out_bank;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, out_full,
    input  req_ready, out_valid, out_data, out_bank
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, out_full,
    output req_ready, out_valid, out_data, out_bank
  );
endinterface
`default_nettype wire

// File: rtl/neighbor_info_banked_engine_req_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : neighbor_info_req_fifo
//  Purpose  : Synchronous request FIFO, generic entry type, power-of-2 depth.
//             Pointers carry one extra wrap bit to tell full from empty.
//  Ports    : clk, reset (async, active-high)
//             push, push_data  - write side (ignored while full)
//             pop, pop_data    - read side, pop_data shows the head entry
//             full, empty      - status from the registered pointers
//  Revision : 1.0 - initial release
// ============================================================================
module neighbor_info_req_fifo
  import neighbor_info_banked_engine_pkg::*;
#(
  parameter type T          = neighbor_info_req_t,
  parameter int  FIFO_DEPTH = NI_FIFO_DEPTH
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty
);
  localparam int             c_pw      = $clog2(FIFO_DEPTH);
  localparam logic [c_pw:0]  c_ptr_one = (c_pw + 1)'(1);

  T              r_mem [FIFO_DEPTH];
  logic [c_pw:0] r_wr_ptr;
  logic [c_pw:0] r_rd_ptr;
  logic          w_push;
  logic          w_pop;

  // Full is judged on the pointers at cycle start, so a pop in the same
  // cycle never makes room for a push.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[c_pw-1:0]] <= push_data;
  end

  assign pop_data = r_mem[r_rd_ptr[c_pw-1:0]];
  assign empty    = (r_wr_ptr == r_rd_ptr);
  assign full     = (r_wr_ptr[c_pw] != r_rd_ptr[c_pw]) &&
                    (r_wr_ptr[c_pw-1:0] == r_rd_ptr[c_pw-1:0]);
endmodule
`default_nettype wire

// File: rtl/neighbor_info_banked_engine.sv
`default_nettype none
// ============================================================================
//  Module   : neighbor_info_banked_engine
//  Purpose  : Queues read/write requests and services them in order against
//             NUM_BANK synchronous single-port banks, each split into two
//             ping-pong regions selected by the replay-iteration parity.
//             Reads use the current region, writes the other one.
//  Ports    : clk                      - clock, rising edge
//             reset                    - async active-high reset
//             last_bit_Cur_Replay_Iter - replay parity (region select)
//             bus (slave)              - request / response bus
//  Revision : 1.0 - initial release
// ============================================================================
module neighbor_info_banked_engine
  import neighbor_info_banked_engine_pkg::*;
#(
  parameter int NUM_BANK   = NI_NUM_BANK,
  parameter int DATA_W     = NI_DATA_W,
  parameter int DEPTH      = NI_DEPTH,
  parameter int FIFO_DEPTH = NI_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         last_bit_Cur_Replay_Iter,
  neighbor_info_banked_engine_if.slave bus
);
  localparam int c_aw = $clog2(NUM_BANK * DEPTH);
  localparam int c_bw = $clog2(NUM_BANK);
  localparam int c_rw = $clog2(DEPTH);

  neighbor_info_req_t   w_push_req;
  neighbor_info_req_t   w_head;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_head_is_wr;
  logic                 w_issue;
  logic [c_bw-1:0]      w_head_bank;
  logic [c_rw-1:0]      w_head_row;
  logic [DATA_W-1:0]    w_head_wdata;
  logic                 w_region;
  logic [c_rw:0]        w_mem_idx;
  logic [DATA_W-1:0]    w_bank_q [NUM_BANK];
  logic                 w_unused_head;

  neighbor_info_state_t r_state;
  logic [c_bw-1:0]      r_rd_bank;
  logic                 r_out_valid;
  logic [DATA_W-1:0]    r_out_data;
  logic [c_bw-1:0]      r_out_bank;

  always_comb begin
    w_push_req       = '0;
    w_push_req.op    = bus.req_op;
    w_push_req.addr  = NI_ADDR_MAX_W'(bus.req_addr);
    w_push_req.wdata = NI_DATA_MAX_W'(bus.req_wdata);
  end

  neighbor_info_req_fifo #(
    .T          (neighbor_info_req_t),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.req_valid),
    .push_data (w_push_req),
    .pop       (w_issue),
    .pop_data  (w_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  assign bus.req_ready = !w_fifo_full;

  // Head decode: low address bits pick the bank, the rest the row.
  assign w_head_is_wr  = (w_head.op == OP_WRITE);
  assign w_head_bank   = w_head.addr[c_bw-1:0];
  assign w_head_row    = w_head.addr[c_aw-1:c_bw];
  assign w_head_wdata  = w_head.wdata[DATA_W-1:0];
  assign w_unused_head = ^w_head;

  // Writes always drain; a read at the head waits for downstream room, and
  // everything queued behind it waits too so order is preserved.
  assign w_issue   = (r_state == ST_IDLE) && !w_fifo_empty &&
                     (w_head_is_wr || !bus.out_full);
  assign w_region  = w_head_is_wr ? ~last_bit_Cur_Replay_Iter
                                  : last_bit_Cur_Replay_Iter;
  assign w_mem_idx = {w_region, w_head_row};

  for (genvar g = 0; g < NUM_BANK; g++) begin : g_bank
    logic [DATA_W-1:0] r_mem [2*DEPTH];
    logic [DATA_W-1:0] r_q;
    logic              w_en;

    assign w_en = w_issue && (w_head_bank == c_bw'(g));

    // Storage is deliberately not reset: contents survive engine reset.
    always_ff @(posedge clk) begin
      if (w_en) begin
        if (w_head_is_wr) r_mem[w_mem_idx] <= w_head_wdata;
        else              r_q              <= r_mem[w_mem_idx];
      end
    end

    assign w_bank_q[g] = r_q;
  end

  // Read issued in IDLE -> bank Q valid during RD_WAIT -> captured into the
  // output registers, giving a one-cycle strobe two cycles after the pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rd_bank   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_bank  <= '0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_issue && !w_head_is_wr) begin
            r_rd_bank <= w_head_bank;
            r_state   <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_bank_q[r_rd_bank];
          r_out_bank  <= r_rd_bank;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_bank  = r_out_bank;
endmodule
`default_nettype wire

// File: tb/tb_neighbor_info_banked_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_neighbor_info_banked_engine
//  Purpose  : Self-checking bench for neighbor_info_banked_engine. A flat
//             two-region memory model and an in-order queue of expected read
//             results check every out_valid pulse; directed sequences cover
//             latency, backpressure, full-FIFO behaviour and reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_neighbor_info_banked_engine;
  localparam int NUM_BANK   = 4;
  localparam int DATA_W     = 16;
  localparam int DEPTH      = 128;
  localparam int FIFO_DEPTH = 8;
  localparam int AW         = $clog2(NUM_BANK * DEPTH);
  localparam int BW         = $clog2(NUM_BANK);
  localparam int NADDR      = NUM_BANK * DEPTH;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [BW-1:0]     bank;
  } exp_t;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic replay = 1'b0;

  neighbor_info_banked_engine_if #(
    .NUM_BANK (NUM_BANK), .DATA_W (DATA_W), .DEPTH (DEPTH)
  ) bus ();

  neighbor_info_banked_engine #(
    .NUM_BANK (NUM_BANK), .DATA_W (DATA_W), .DEPTH (DEPTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .last_bit_Cur_Replay_Iter (replay),
    .bus                      (bus)
  );

  always #5 clk = ~clk;

  int                n_checks = 0;
  int                n_fail   = 0;
  int                cyc      = 0;
  exp_t              exp_q[$];
  int                pulse_cyc[$];
  logic [DATA_W-1:0] seen_data[$];
  logic [DATA_W-1:0] mdl_mem [2][NADDR];
  logic              prev_valid = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Response monitor: every strobe must match the oldest outstanding read.
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid === 1'b1) begin
      chk("back_to_back_valid", prev_valid, 0);
      pulse_cyc.push_back(cyc);
      seen_data.push_back(bus.out_data);
      chk("read_outstanding", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_data", bus.out_data, e.data);
        chk("out_bank", bus.out_bank, e.bank);
      end
    end
    prev_valid = bus.out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the engine behaves like one flat memory per region;
  // reads see the replay region, writes land in the other one.
  task automatic model_accept(input logic op, input logic [AW-1:0] addr,
                              input logic [DATA_W-1:0] wd);
    exp_t e;
    if (op) begin
      mdl_mem[~replay][addr] = wd;
    end else begin
      e.data = mdl_mem[replay][addr];
      e.bank = addr[BW-1:0];
      exp_q.push_back(e);
    end
  endtask

  task automatic drive(input logic op, input logic [AW-1:0] addr,
                       input logic [DATA_W-1:0] wd, output logic acc);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    acc           = bus.req_ready;
    tick();
    if (acc) model_accept(op, addr, wd);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int b = budget;
    while (exp_q.size() != 0 && b > 0) begin
      tick();
      b--;
    end
    chk("drain_outstanding", exp_q.size(), 0);
    repeat (2 * FIFO_DEPTH + 2) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    logic v, op;
    logic [AW-1:0] a;

    bus.req_valid = 1'b0;
    bus.req_op    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.out_full  = 1'b0;

    // Reset state, seen before any clock edge
    #2;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data",  bus.out_data,  0);
    chk("rst_out_bank",  bus.out_bank,  0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tick();

    // Fill both regions of every bank so any read has a known value
    for (int r = 0; r < 2; r++) begin
      replay = 1'(r);
      for (int i = 0; i < NADDR; i++) drive(1'b1, AW'(i), DATA_W'($urandom), acc);
      repeat (4) tick();
    end

    // Write in replay 0, read back in replay 1, exact latency
    replay = 1'b0;
    drive(1'b1, AW'(5), DATA_W'(16'hBEEF), acc);
    repeat (3) tick();
    replay = 1'b1;
    drive(1'b0, AW'(5), '0, acc);
    chk("t39_valid_T", bus.out_valid, 0);
    tick();
    chk("t39_valid_T1", bus.out_valid, 0);
    tick();
    chk("t39_valid_T2", bus.out_valid, 1);
    chk("t39_data", bus.out_data, 16'hBEEF);
    chk("t39_bank", bus.out_bank, 1);
    tick();
    chk("t39_valid_T3", bus.out_valid, 0);
    wait_drain(20);

    // Interleaved writes/reads of one address across replay toggles
    seen_data.delete();
    replay = 1'b0;
    drive(1'b1, AW'(3), DATA_W'(1), acc);
    repeat (3) tick();
    replay = 1'b1;
    drive(1'b0, AW'(3), '0, acc);
    wait_drain(20);
    drive(1'b1, AW'(3), DATA_W'(2), acc);
    repeat (3) tick();
    replay = 1'b0;
    drive(1'b0, AW'(3), '0, acc);
    wait_drain(20);
    chk("t41_count", seen_data.size(), 2);
    if (seen_data.size() == 2) begin
      chk("t41_first",  seen_data[0], 1);
      chk("t41_second", seen_data[1], 2);
    end

    // Backpressure: 8 reads fill the FIFO, the 9th is dropped
    bus.out_full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("t40_ready_fill", bus.req_ready, (i < FIFO_DEPTH) ? 1 : 0);
      drive(1'b0, AW'(20 + i), '0, acc);
    end
    chk("t40_ready_full", bus.req_ready, 0);
    repeat (3) tick();
    chk("t40_no_valid_stalled", bus.out_valid, 0);
    pulse_cyc.delete();
    bus.out_full = 1'b0;
    wait_drain(4 * FIFO_DEPTH + 10);
    chk("t40_pulses", pulse_cyc.size(), FIFO_DEPTH);
    for (int i = 1; i < pulse_cyc.size(); i++)
      chk("t40_gap", pulse_cyc[i] - pulse_cyc[i-1], 2);

    // Push on a full FIFO in the same cycle as a pop is dropped
    bus.out_full = 1'b1;
    for (int i = 0; i < FIFO_DEPTH; i++) drive(1'b0, AW'(40 + i), '0, acc);
    pulse_cyc.delete();
    bus.out_full = 1'b0;
    chk("t43_ready_at_pop", bus.req_ready, 0);
    drive(1'b0, AW'(60), '0, acc);
    chk("t43_ready_after_pop", bus.req_ready, 1);
    drive(1'b0, AW'(61), '0, acc);
    chk("t43_ready_refull", bus.req_ready, 0);
    wait_drain(4 * FIFO_DEPTH + 10);
    chk("t43_pulses", pulse_cyc.size(), FIFO_DEPTH + 1);

    // Reset while a read is in RD_WAIT
    replay = 1'b1;
    drive(1'b0, AW'(5), '0, acc);
    tick();
    reset = 1'b1;
    #1;
    chk("t42_ready",     bus.req_ready, 1);
    chk("t42_out_valid", bus.out_valid, 0);
    chk("t42_out_data",  bus.out_data,  0);
    chk("t42_out_bank",  bus.out_bank,  0);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    pulse_cyc.delete();
    tick();
    tick();
    reset = 1'b0;
    repeat (4) tick();
    chk("t42_no_valid_after_reset", pulse_cyc.size(), 0);
    seen_data.delete();
    drive(1'b0, AW'(5), '0, acc);
    wait_drain(20);
    chk("t42_readback_count", seen_data.size(), 1);
    if (seen_data.size() == 1) chk("t42_readback", seen_data[0], 16'hBEEF);

    // Randomised traffic; replay toggles only once the engine is drained
    for (int seg = 0; seg < 4; seg++) begin
      replay = 1'(seg % 2);
      for (int c = 0; c < 150; c++) begin
        v  = ($urandom_range(0, 9) < 7);
        op = ($urandom_range(0, 2) == 0);
        a  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NADDR - 1))
                                         : AW'($urandom_range(0, 15));
        bus.out_full = ($urandom_range(0, 3) == 0);
        if (v) drive(op, a, DATA_W'($urandom), acc);
        else   tick();
      end
      bus.out_full = 1'b0;
      wait_drain(4 * FIFO_DEPTH + 20);
    end

    chk("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
